// File: rtl/n_bit_adder.sv
// Registered N-bit ripple-carry adder: {cout, sum} = a + b + cin, one-cycle latency.
// Define N_BIT_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module n_bit_adder #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         out_valid
`ifdef N_BIT_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    logic [N-1:0] sum_d, sum_q;
    logic         cout_d, cout_q;
    logic         out_valid_q;

    // Ripple chain of full adders; c carries the running carry between stages.
    always_comb begin
        logic c;
        c     = cin;
        sum_d = '0;
        for (int i = 0; i < int'(N); i++) begin
            sum_d[i] = a[i] ^ b[i] ^ c;
            c        = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout_d = c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = out_valid_q;

`ifdef N_BIT_ADDER_OVF_EN
    logic ovf_d, ovf_q;

    // Operands of equal sign producing a result of the other sign.
    assign ovf_d = (a[N-1] == b[N-1]) && (sum_d[N-1] != a[N-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_n_bit_adder.sv
// Self-checking bench for n_bit_adder (N=16): directed corner cases plus random vectors
// checked through a one-deep scoreboard against an integer reference model.
module tb_n_bit_adder;

    localparam int unsigned N = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic         out_valid;
`ifdef N_BIT_ADDER_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   checks;
    int   errors;

    n_bit_adder #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .cout     (cout),
        .out_valid(out_valid)
`ifdef N_BIT_ADDER_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic exp_v);
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        chk("sum", 64'(sum), 64'(held.sum));
        chk("cout", 64'(cout), 64'(held.cout));
`ifdef N_BIT_ADDER_OVF_EN
        chk("ovf", 64'(ovf), 64'(held.ovf));
`endif
    endtask

    // Drive one cycle of stimulus, then compare the result registered at that edge.
    task automatic cycle(input logic v, input logic [N-1:0] ai, input logic [N-1:0] bi,
                         input logic ci);
        exp_t   e;
        longint full;
        longint s;
        logic   exp_v;
        @(negedge clk);
        in_valid = v;
        a        = ai;
        b        = bi;
        cin      = ci;
        if (v) begin
            full   = longint'(ai) + longint'(bi) + longint'(ci);
            s      = longint'($signed(ai)) + longint'($signed(bi)) + longint'(ci);
            e.sum  = full[N-1:0];
            e.cout = full[N];
            e.ovf  = (s > 32767) || (s < -32768);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        exp_v = (sb.size() != 0);
        if (exp_v) held = sb.pop_front();
        check_outputs(exp_v);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        held     = '0;
        rst      = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        #2 rst = 1'b1;
        #1 check_outputs(1'b0);

        // Valid input at an edge while reset is still high must be ignored.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'd5;
        b        = 16'd7;
        @(posedge clk);
        #1 check_outputs(1'b0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        cycle(1'b1, 16'd12, 16'd120, 1'b1);
        cycle(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        cycle(1'b1, 16'h7FFF, 16'h0000, 1'b1);
        cycle(1'b1, 16'h8000, 16'hFFFF, 1'b0);
        cycle(1'b1, 16'h1234, 16'h4321, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'hAAAA, 16'h5555, 1'b1);

        // Asynchronous reset between edges clears outputs without a clock.
        cycle(1'b1, 16'h0F0F, 16'hF0F0, 1'b0);
        #2 rst = 1'b1;
        sb.delete();
        held = '0;
        #1 check_outputs(1'b0);
        @(negedge clk);
        rst = 1'b0;

        cycle(1'b1, 16'h0001, 16'h0001, 1'b0);
        cycle(1'b1, 16'h0000, 16'h0000, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 3) != 0, N'($urandom), N'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
